// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_pkg
// Description : Shared types for the hazard unit: scoreboard slot entry,
//               stall FSM state encoding and forwarding read-port codes.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_unit_pkg;

  // Register-select width carried in a scoreboard slot.
  localparam int HU_REGBITS = 5;

  typedef logic [HU_REGBITS-1:0] regbits_t;

  // One pipeline-stage shadow of a destination register.
  typedef struct packed {
    logic     valid;
    regbits_t wsel;
    logic     memtoreg;
  } sb_entry_t;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hu_state_t;

  localparam logic [1:0] RPORT_RS = 2'b01;
  localparam logic [1:0] RPORT_RT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_if
// Description : Bundle of every hazard-unit signal. The hu modport is the
//               unit's view, the tb modport the pipeline/bench view.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_unit_if #(
  parameter int REGBITS = 5,
  parameter int CNTBITS = 16
);
  logic               ihit;
  logic               dhit;
  logic               mem_access;
  logic [REGBITS-1:0] dec_rs;
  logic [REGBITS-1:0] dec_rt;
  logic               dec_rs_used;
  logic               dec_rt_used;
  logic [REGBITS-1:0] dec_wsel;
  logic               dec_RegWrite;
  logic               dec_MemtoReg;
  logic               flush_ex;
  logic               pc_en;
  logic               ifid_en;
  logic               idex_en;
  logic               idex_bubble;
  logic               ifid_flush;
  logic               exmem_en;
  logic               hazard_dec;
  logic [1:0]         rport_dec;
  logic               hazard_ex;
  logic [1:0]         rport_ex;
  logic               MemtoReg_ex;
  logic               MemtoReg_mem;
  logic [CNTBITS-1:0] lu_stall_count;

  modport hu (
    input  ihit, dhit, mem_access, dec_rs, dec_rt, dec_rs_used, dec_rt_used,
           dec_wsel, dec_RegWrite, dec_MemtoReg, flush_ex,
    output pc_en, ifid_en, idex_en, idex_bubble, ifid_flush, exmem_en,
           hazard_dec, rport_dec, hazard_ex, rport_ex, MemtoReg_ex,
           MemtoReg_mem, lu_stall_count
  );

  modport tb (
    output ihit, dhit, mem_access, dec_rs, dec_rt, dec_rs_used, dec_rt_used,
           dec_wsel, dec_RegWrite, dec_MemtoReg, flush_ex,
    input  pc_en, ifid_en, idex_en, idex_bubble, ifid_flush, exmem_en,
           hazard_dec, rport_dec, hazard_ex, rport_ex, MemtoReg_ex,
           MemtoReg_mem, lu_stall_count
  );
endinterface
`default_nettype wire

// File: rtl/hu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hu_scoreboard
// Description : Two-slot destination-register shift register shadowing the
//               ID/EX and EX/MEM latches.
//   CLK, nRST      clock / async active-low reset
//   freeze_i       hold both slots
//   bubble_i       load an empty entry into the EX slot on advance
//   dec_entry_i    destination info of the decode instruction
//   ex_slot_o      entry for the instruction now in EX
//   mem_slot_o     entry for the instruction now in MEM
// Revision    : 1.0 - initial release
// ============================================================================
module hu_scoreboard
  import hazard_unit_pkg::*;
(
  input  logic      CLK,
  input  logic      nRST,
  input  logic      freeze_i,
  input  logic      bubble_i,
  input  sb_entry_t dec_entry_i,
  output sb_entry_t ex_slot_o,
  output sb_entry_t mem_slot_o
);

  sb_entry_t ex_slot_q;
  sb_entry_t mem_slot_q;
  sb_entry_t ex_slot_d;

  // r0 is hard-wired zero, so a write to it never produces a hazard.
  always_comb begin
    ex_slot_d = dec_entry_i;
    ex_slot_d.valid = dec_entry_i.valid && (dec_entry_i.wsel != '0);
    if (bubble_i) begin
      ex_slot_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_slot_q  <= '0;
      mem_slot_q <= '0;
    end else if (!freeze_i) begin
      mem_slot_q <= ex_slot_q;
      ex_slot_q  <= ex_slot_d;
    end
  end

  assign ex_slot_o  = ex_slot_q;
  assign mem_slot_o = mem_slot_q;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : RAW hazard detector and stall controller for the 5-stage
//               core. Drives pipeline-latch enables, load-use stalls,
//               branch-flush bubbles and the forwarding-unit selects.
//   Inputs : CLK, nRST, ihit, dhit, mem_access, dec_rs/rt(_used),
//            dec_wsel, dec_RegWrite, dec_MemtoReg, flush_ex
//   Outputs: pc_en, ifid_en, idex_en, idex_bubble, ifid_flush, exmem_en,
//            hazard_dec, rport_dec, hazard_ex, rport_ex, MemtoReg_ex,
//            MemtoReg_mem, lu_stall_count
//   REGBITS must equal the package slot width (HU_REGBITS).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REGBITS = HU_REGBITS,
  parameter int CNTBITS = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               mem_access,
  input  logic [REGBITS-1:0] dec_rs,
  input  logic [REGBITS-1:0] dec_rt,
  input  logic               dec_rs_used,
  input  logic               dec_rt_used,
  input  logic [REGBITS-1:0] dec_wsel,
  input  logic               dec_RegWrite,
  input  logic               dec_MemtoReg,
  input  logic               flush_ex,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               idex_en,
  output logic               idex_bubble,
  output logic               ifid_flush,
  output logic               exmem_en,
  output logic               hazard_dec,
  output logic [1:0]         rport_dec,
  output logic               hazard_ex,
  output logic [1:0]         rport_ex,
  output logic               MemtoReg_ex,
  output logic               MemtoReg_mem,
  output logic [CNTBITS-1:0] lu_stall_count
);

  hu_state_t        state_q, state_d;
  logic [1:0]       rport_ex_q, rport_ex_d;
  logic [CNTBITS-1:0] count_q;
  logic             freeze;
  logic             lu_enter;
  sb_entry_t        dec_entry;
  sb_entry_t        ex_slot;
  sb_entry_t        mem_slot;
  logic             rs_ex, rt_ex, rs_mem, rt_mem;
  logic             ex_load;
  logic             lu_hit;

  // A cache miss on either port stalls the whole pipeline.
  assign freeze = !ihit || (mem_access && !dhit);

  assign dec_entry.valid    = dec_RegWrite;
  assign dec_entry.wsel     = regbits_t'(dec_wsel);
  assign dec_entry.memtoreg = dec_MemtoReg;

  hu_scoreboard u_scoreboard (
    .CLK         (CLK),
    .nRST        (nRST),
    .freeze_i    (freeze),
    .bubble_i    (idex_bubble),
    .dec_entry_i (dec_entry),
    .ex_slot_o   (ex_slot),
    .mem_slot_o  (mem_slot)
  );

  assign rs_ex  = dec_rs_used && ex_slot.valid  && (regbits_t'(dec_rs) == ex_slot.wsel);
  assign rt_ex  = dec_rt_used && ex_slot.valid  && (regbits_t'(dec_rt) == ex_slot.wsel);
  assign rs_mem = dec_rs_used && mem_slot.valid && (regbits_t'(dec_rs) == mem_slot.wsel);
  assign rt_mem = dec_rt_used && mem_slot.valid && (regbits_t'(dec_rt) == mem_slot.wsel);

  assign MemtoReg_ex  = ex_slot.memtoreg  && ex_slot.valid;
  assign MemtoReg_mem = mem_slot.memtoreg && mem_slot.valid;
  assign ex_load      = MemtoReg_ex;

  // The youngest producer (EX) shadows MEM. A load in EX cannot forward yet,
  // so that operand reports no decode forward; the stall handles it instead.
  assign rport_dec[0] = rs_ex ? !ex_load : rs_mem;
  assign rport_dec[1] = rt_ex ? !ex_load : rt_mem;
  assign hazard_dec   = |rport_dec;

  assign lu_hit = ex_load && (rs_ex || rt_ex);

  always_comb begin
    state_d     = state_q;
    rport_ex_d  = rport_ex_q;
    lu_enter    = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (!freeze) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      rport_ex_d = '0;
      if (flush_ex) begin
        // Squash the wrong-path decode instruction; any pending stall dies.
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        state_d     = RUN;
      end else begin
        case (state_q)
          RUN: begin
            if (lu_hit) begin
              pc_en       = 1'b0;
              ifid_en     = 1'b0;
              idex_bubble = 1'b1;
              lu_enter    = 1'b1;
              state_d     = LU_STALL;
            end
          end
          LU_STALL: begin
            // Load has reached MEM; remember which consumer ports need it
            // once the consumer itself moves into EX.
            rport_ex_d = ({rt_mem, rs_mem} & (RPORT_RS | RPORT_RT))
                         & {2{MemtoReg_mem}};
            state_d    = RUN;
          end
          default: state_d = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= RUN;
      rport_ex_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rport_ex_q <= rport_ex_d;
      if (lu_enter && (count_q != {CNTBITS{1'b1}})) begin
        count_q <= count_q + {{(CNTBITS-1){1'b0}}, 1'b1};
      end
    end
  end

  assign rport_ex       = rport_ex_q;
  assign hazard_ex      = |rport_ex_q;
  assign lu_stall_count = count_q;

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard detector and stall controller for the 5-stage MIPS core. It sits directly upstream of the forwarding unit and drives that unit's hazard_dec, hazard_ex, rport_dec, rport_ex, MemtoReg_ex and MemtoReg_mem inputs.
- Keeps its own destination-register scoreboard, shadowing the ID/EX and EX/MEM latches.
- Detects RAW hazards and inserts load-use stalls and branch-flush bubbles.
- Drives the pipeline-latch enables.

Parameters:
- REGBITS, 5, register-select width.
- CNTBITS, 16, width of the load-use stall performance counter.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- mem_access  in  1  instruction in MEM has dREN or dWEN set.
- dec_rs  in  REGBITS  rs of instruction in decode.
- dec_rt  in  REGBITS  rt of instruction in decode.
- dec_rs_used  in  1  decode instruction reads rs.
- dec_rt_used  in  1  decode instruction reads rt.
- dec_wsel  in  REGBITS  destination of decode instruction.
- dec_RegWrite  in  1  decode instruction writes a register.
- dec_MemtoReg  in  1  decode instruction is a load.
- flush_ex  in  1  branch/jump taken, resolved in EX.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID latch enable.
- idex_en  out  1  ID/EX latch enable.
- idex_bubble  out  1  load a NOP into ID/EX.
- ifid_flush  out  1  clear IF/ID.
- exmem_en  out  1  EX/MEM and MEM/WB latch enable.
- hazard_dec  out  1  a decode operand needs forwarding.
- rport_dec  out  2  bit0 = rs/rdat1, bit1 = rt/rdat2.
- hazard_ex  out  1  an EX operand needs forwarding from MEM.
- rport_ex  out  2  bit0 = porta_ex, bit1 = rdat2_ex.
- MemtoReg_ex  out  1  EX-slot producer is a load.
- MemtoReg_mem  out  1  MEM-slot producer is a load.
- lu_stall_count  out  CNTBITS  saturating count of load-use stall cycles.

Behaviour:
- Scoreboard:
  - Registered slots ex_slot and mem_slot, each holding {valid, wsel, memtoreg}.
  - A slot whose wsel == 0 is written with valid = 0.
  - Reset clears both slots to valid = 0.
- freeze = !ihit | (mem_access & !dhit).
  - While freeze: all enables are 0 and slots and FSM hold.
- Advance (when !freeze):
  - mem_slot <= ex_slot.
  - ex_slot <= decode info, or invalid if idex_bubble.
- Matching: rs_ex = dec_rs_used & ex_slot.valid & dec_rs == ex_slot.wsel. rt_ex, rs_mem and rt_mem are defined the same way.
- hazard_dec / rport_dec:
  - A port's bit is set if the operand matches the EX slot and that slot is not a load, or matches the MEM slot.
  - On a match in both slots, the EX slot wins.
  - hazard_dec = |rport_dec.
- FSM RUN / LU_STALL, reset state RUN:
  - RUN -> LU_STALL when !freeze & !flush_ex and a decode operand matches an EX-slot load. In that cycle: pc_en = 0, ifid_en = 0, idex_bubble = 1.
  - LU_STALL -> RUN on the next !freeze cycle.
- hazard_ex / rport_ex:
  - Registered. Set on the advance that leaves LU_STALL.
  - The bits record which operands matched the load, which is now in MEM.
  - Cleared on any other advance. Held during freeze.
- MemtoReg_ex = ex_slot.memtoreg & ex_slot.valid. MemtoReg_mem is defined the same way on mem_slot.
- flush_ex has priority over the load-use stall:
  - ifid_flush = 1 and idex_bubble = 1, which squashes the wrong-path decode instruction.
  - pc_en = 1. FSM forced to RUN.
- Default when not frozen: all enables 1, idex_bubble = 0, ifid_flush = 0.
- lu_stall_count:
  - Increments once per RUN -> LU_STALL transition and saturates at all-ones.
  - Reset value 0.
- Output reset values:
  - Combinational enables follow the rules above.
  - hazard_ex = 0, rport_ex = 0, lu_stall_count = 0.
- Reset mid-stall returns the FSM to RUN with empty slots.

Decomposition:
- Add to cpu_types_pkg:
  - typedef sb_entry_t {logic valid; regbits_t wsel; logic memtoreg;}.
  - enum hu_state_t {RUN, LU_STALL}.
  - Constants RPORT_RS = 2'b01, RPORT_RT = 2'b10.
- Add an interface hazard_unit_if with hu and tb modports.
- One natural sub-module: hu_scoreboard, the two-slot shift register with freeze and bubble inputs. Matching and the FSM stay in hazard_unit.

Test Plan:
- ADD r3 then ADD r4, r3, r5 back-to-back -> hazard_dec = 1, rport_dec = 01, no stall, lu_stall_count = 0.
- LW r2 then SUB r6, r1, r2:
  - In the cycle LW is in EX: pc_en = 0, idex_bubble = 1.
  - Next advance: hazard_ex = 1, rport_ex = 10, MemtoReg_mem = 1.
  - lu_stall_count = 1.
- LW r2 with a load-use consumer and flush_ex = 1 in the same cycle -> ifid_flush = 1, no LU_STALL entry, count unchanged.
- Producer writes r0, consumer reads r0 -> hazard_dec = 0, rport_dec = 00.
- Load-use stall while mem_access = 1 & dhit = 0 for 3 cycles -> all enables 0 for 3 cycles, FSM stays LU_STALL, releases on dhit.
- Assert nRST low during LU_STALL -> FSM RUN, slots invalid, hazard_ex = 0, count = 0 immediately, with no clock edge.
